// File: rtl/char_disp_pkg.sv
// Shared constants and types for the character line display: font geometry,
// glyph ROM layout and the per-slot storage record.
package char_disp_pkg;

  localparam int FONT_W     = 5;
  localparam int FONT_H     = 8;
  localparam int ROM_ADDR_W = 9;

  typedef logic [ROM_ADDR_W-1:0] rom_addr_t;

  localparam rom_addr_t BLANK_ADDR = 9'h000;

  // Glyph n occupies FONT_H consecutive ROM rows starting at n*FONT_H.
  localparam rom_addr_t GLYPH_BLANK = 9'h000;
  localparam rom_addr_t GLYPH_A     = 9'h008;
  localparam rom_addr_t GLYPH_B     = 9'h010;
  localparam rom_addr_t GLYPH_C     = 9'h018;
  localparam rom_addr_t GLYPH_D     = 9'h020;
  localparam rom_addr_t GLYPH_E     = 9'h028;
  localparam rom_addr_t GLYPH_F     = 9'h030;

  typedef struct packed {
    rom_addr_t base;
    logic      blink;
  } slot_t;

  localparam slot_t SLOT_RESET = '{base: BLANK_ADDR, blink: 1'b0};

  function automatic rom_addr_t glyph_base(input int unsigned glyph_idx);
    glyph_base = rom_addr_t'(glyph_idx * FONT_H);
  endfunction

endpackage

// File: rtl/char_line_display_blink_timer.sv
// Counts frame ticks and toggles blink_phase once every BLINK_FRAMES ticks.
module blink_timer #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_tick,
  output logic blink_phase
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             phase_d, phase_q;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (frame_tick) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = {CNT_W{1'b0}};
        phase_d = ~phase_q;
      end else begin
        cnt_d   = cnt_q + CNT_W'(1);
        phase_d = phase_q;
      end
    end else begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= {CNT_W{1'b0}};
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign blink_phase = phase_q;

endmodule

// File: rtl/char_line_display.sv
// Draws a scaled line of NUM_CHARS glyphs inside a fixed box; three-stage
// pixel pipeline (decode, ROM address, pixel select) with runtime slot writes.
module char_line_display
  import char_disp_pkg::*;
#(
  parameter logic [10:0] X_BOX        = 11'd88,
  parameter logic [9:0]  Y_BOX        = 10'd32,
  parameter int          NUM_CHARS    = 8,
  parameter int          SCALE_LOG2   = 2,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic                                                 clk,
  input  logic                                                 rst_n,
  input  logic [10:0]                                          pixel_x,
  input  logic [9:0]                                           pixel_y,
  input  logic                                                 pixel_valid,
  input  logic                                                 wr_en,
  input  logic [((NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1)-1:0] wr_idx,
  input  logic [8:0]                                           wr_base,
  input  logic                                                 wr_blink,
  input  logic                                                 frame_tick,
  output logic [8:0]                                           rom_addr,
  input  logic [FONT_W-1:0]                                    rom_data,
  output logic                                                 pixel_on,
  output logic                                                 pixel_on_valid
);

  localparam int IDX_W  = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
  localparam int COL_W  = $clog2(FONT_W + 1);
  localparam int ROW_W  = $clog2(FONT_H);
  localparam int CELL_W = (FONT_W + 1) << SCALE_LOG2;
  localparam int BOX_W  = NUM_CHARS * CELL_W;
  localparam int BOX_H  = FONT_H << SCALE_LOG2;
  localparam int X_END  = int'(X_BOX) + BOX_W;
  localparam int Y_END  = int'(Y_BOX) + BOX_H;

  logic blink_phase_s;

  blink_timer #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .blink_phase(blink_phase_s)
  );

  // Slot storage
  slot_t slots_d [NUM_CHARS];
  slot_t slots_q [NUM_CHARS];

  // Stage 1 decode
  logic [10:0]      dx_s;
  logic [9:0]       dy_s;
  logic             in_box_s;
  logic [IDX_W-1:0] slot_s;
  logic [COL_W-1:0] col_s;
  logic [ROW_W-1:0] row_s;

  logic             v1_q, in_box1_q;
  logic [IDX_W-1:0] slot1_q;
  logic [COL_W-1:0] col1_q;
  logic [ROW_W-1:0] row1_q;

  // Stage 2 address / attribute fetch
  slot_t            rd_slot_s;
  logic [8:0]       rom_addr_s;
  logic             gap_s;

  logic             v2_q, in_box2_q, gap2_q, blink2_q, phase2_q;
  logic [COL_W-1:0] col2_q;

  // Stage 3 pixel select
  logic             rom_bit_s;
  logic             on_s;
  logic             v3_q, on_q;

  always_comb begin
    slots_d = slots_q;
    if (wr_en && (int'(wr_idx) < NUM_CHARS)) begin
      slots_d[wr_idx] = '{base: wr_base, blink: wr_blink};
    end else begin
      slots_d = slots_q;
    end
  end

  // Constant divisors keep slot/column extraction purely combinational.
  always_comb begin
    dx_s     = pixel_x - X_BOX;
    dy_s     = pixel_y - Y_BOX;
    in_box_s = (int'(pixel_x) >= int'(X_BOX)) && (int'(pixel_x) < X_END) &&
               (int'(pixel_y) >= int'(Y_BOX)) && (int'(pixel_y) < Y_END);
    if (in_box_s) begin
      slot_s = IDX_W'(int'(dx_s) / CELL_W);
      col_s  = COL_W'((int'(dx_s) % CELL_W) >> SCALE_LOG2);
      row_s  = ROW_W'(int'(dy_s) >> SCALE_LOG2);
    end else begin
      slot_s = {IDX_W{1'b0}};
      col_s  = {COL_W{1'b0}};
      row_s  = {ROW_W{1'b0}};
    end
  end

  always_comb begin
    rd_slot_s  = slots_q[slot1_q];
    rom_addr_s = rd_slot_s.base + {{(ROM_ADDR_W - ROW_W){1'b0}}, row1_q};
    gap_s      = (col1_q == COL_W'(FONT_W));
  end

  // Column 0 is the leftmost pixel, held in the MSB of the ROM row.
  always_comb begin
    rom_bit_s = 1'b0;
    for (int i = 0; i < FONT_W; i++) begin
      rom_bit_s = (col2_q == COL_W'(i)) ? rom_data[FONT_W-1-i] : rom_bit_s;
    end
    on_s = v2_q & in_box2_q & ~gap2_q & rom_bit_s & ~(blink2_q & phase2_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CHARS; i++) begin
        slots_q[i] <= SLOT_RESET;
      end
      v1_q      <= 1'b0;
      in_box1_q <= 1'b0;
      slot1_q   <= {IDX_W{1'b0}};
      col1_q    <= {COL_W{1'b0}};
      row1_q    <= {ROW_W{1'b0}};
      v2_q      <= 1'b0;
      in_box2_q <= 1'b0;
      gap2_q    <= 1'b0;
      blink2_q  <= 1'b0;
      phase2_q  <= 1'b0;
      col2_q    <= {COL_W{1'b0}};
      v3_q      <= 1'b0;
      on_q      <= 1'b0;
    end else begin
      slots_q   <= slots_d;
      v1_q      <= pixel_valid;
      in_box1_q <= in_box_s;
      slot1_q   <= slot_s;
      col1_q    <= col_s;
      row1_q    <= row_s;
      v2_q      <= v1_q;
      in_box2_q <= in_box1_q;
      gap2_q    <= gap_s;
      blink2_q  <= rd_slot_s.blink;
      phase2_q  <= blink_phase_s;
      col2_q    <= col1_q;
      v3_q      <= v2_q;
      on_q      <= on_s;
    end
  end

  assign rom_addr       = rom_addr_s;
  assign pixel_on       = on_q;
  assign pixel_on_valid = v3_q;

endmodule

// File: tb/tb_char_line_display.sv
// Scoreboard bench for char_line_display with a 1-cycle glyph ROM model.
module tb_char_line_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] pixel_x;
  logic [9:0]  pixel_y;
  logic        pixel_valid;
  logic        wr_en;
  logic [2:0]  wr_idx;
  logic [8:0]  wr_base;
  logic        wr_blink;
  logic        frame_tick;
  logic [8:0]  rom_addr;
  logic [4:0]  rom_data;
  logic        pixel_on;
  logic        pixel_on_valid;

  char_line_display dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pixel_x       (pixel_x),
    .pixel_y       (pixel_y),
    .pixel_valid   (pixel_valid),
    .wr_en         (wr_en),
    .wr_idx        (wr_idx),
    .wr_base       (wr_base),
    .wr_blink      (wr_blink),
    .frame_tick    (frame_tick),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .pixel_on      (pixel_on),
    .pixel_on_valid(pixel_on_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic on;
    int   cyc;
    int   x;
    int   y;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [8:0] sh_base [8];

  always @(posedge clk) cyc <= cyc + 1;

  // E = 11111,10000,11110,10000,10000,11111,00000,00000; glyph 1 rows = 10001.
  function automatic logic [4:0] font(input logic [8:0] a);
    case (a)
      9'h028:  font = 5'b11111;
      9'h029:  font = 5'b10000;
      9'h02A:  font = 5'b11110;
      9'h02B:  font = 5'b10000;
      9'h02C:  font = 5'b10000;
      9'h02D:  font = 5'b11111;
      default: font = (a >= 9'h008 && a < 9'h010) ? 5'b10001 : 5'b00000;
    endcase
  endfunction

  always @(posedge clk) rom_data <= font(rom_addr);

  function automatic logic model_on(input int x, input int y);
    int dx, s, c, r;
    logic [4:0] bits;
    if (x < 88 || x >= 280 || y < 32 || y >= 64) return 1'b0;
    dx = x - 88;
    s  = dx / 24;
    c  = (dx % 24) / 4;
    r  = (y - 32) / 4;
    if (c == 5) return 1'b0;
    bits = font(sh_base[s] + 9'(r));
    return bits[4-c];
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    pixel_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input int x, input int y, input logic exp_on);
    exp_t e;
    pixel_x     = 11'(x);
    pixel_y     = 10'(y);
    pixel_valid = 1'b1;
    e.on = exp_on; e.cyc = cyc; e.x = x; e.y = y;
    sb.push_back(e);
    tick();
    pixel_valid = 1'b0;
  endtask

  task automatic write_slot(input int idx, input logic [8:0] base, input logic blink);
    wr_en    = 1'b1;
    wr_idx   = 3'(idx);
    wr_base  = base;
    wr_blink = blink;
    tick();
    wr_en = 1'b0;
    sh_base[idx] = base;
  endtask

  task automatic frames(input int n);
    frame_tick = 1'b1;
    for (int i = 0; i < n; i++) tick();
    frame_tick = 1'b0;
    tick();
  endtask

  task automatic drain();
    idle(5);
    check("drain_queue_empty", sb.size(), 0);
  endtask

  // Monitor: pops one expectation per valid output and checks value and latency.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (pixel_on_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = sb.pop_front();
          check($sformatf("pixel_on(%0d,%0d)", e.x, e.y), (pixel_on === 1'b1) ? 1 : 0, int'(e.on));
          check($sformatf("latency(%0d,%0d)", e.x, e.y), cyc - e.cyc, 3);
        end
      end else begin
        check("pixel_on_when_invalid", (pixel_on === 1'b0) ? 0 : 1, 0);
      end
    end
  end

  initial begin
    for (int i = 0; i < 8; i++) sh_base[i] = 9'h000;
    rst_n = 1'b0; pixel_x = 11'd0; pixel_y = 10'd0; pixel_valid = 1'b0;
    wr_en = 1'b0; wr_idx = 3'd0; wr_base = 9'h000; wr_blink = 1'b0; frame_tick = 1'b0;
    idle(3);
    check("reset_pixel_on", int'(pixel_on), 0);
    check("reset_valid", int'(pixel_on_valid), 0);
    check("reset_rom_addr", int'(rom_addr), 0);
    rst_n = 1'b1;
    idle(1);

    write_slot(0, 9'h028, 1'b0);
    write_slot(1, 9'h008, 1'b0);
    send(88, 32, 1'b1);
    check("rom_addr_e_row0", int'(rom_addr), 'h028);
    send(92, 36, 1'b0);
    check("rom_addr_e_row1", int'(rom_addr), 'h029);
    send(96, 40, 1'b1);
    drain();

    // Gap columns, box edges and the start of slot 1.
    for (int x = 108; x < 112; x++) send(x, 32, 1'b0);
    send(280, 32, 1'b0);
    send(88, 64, 1'b0);
    send(87, 32, 1'b0);
    send(279, 63, 1'b0);
    send(112, 32, 1'b1);
    send(116, 32, 1'b0);
    send(128, 63, 1'b1);
    drain();

    for (int x = 88; x < 280; x++) send(x, 32, model_on(x, 32));
    drain();

    // Blink on slot 0: dark after exactly 30 ticks, lit again after 30 more.
    write_slot(0, 9'h028, 1'b1);
    send(88, 32, 1'b1);
    drain();
    frames(29);
    send(88, 32, 1'b1);
    drain();
    frames(1);
    send(88, 32, 1'b0);
    send(96, 40, 1'b0);
    send(112, 32, 1'b1);
    drain();
    frames(30);
    send(88, 32, 1'b1);
    drain();

    // Same-cycle write and read of slot 0: in-flight pixel keeps the old base.
    write_slot(0, 9'h028, 1'b0);
    send(88, 32, 1'b1);
    wr_en = 1'b1; wr_idx = 3'd0; wr_base = 9'h000; wr_blink = 1'b0;
    send(88, 32, 1'b0);
    wr_en = 1'b0;
    sh_base[0] = 9'h000;
    drain();

    // Reset in the middle of a stream.
    write_slot(0, 9'h028, 1'b0);
    for (int x = 88; x < 93; x++) send(x, 32, model_on(x, 32));
    rst_n = 1'b0;
    idle(1);
    check("midreset_pixel_on", int'(pixel_on), 0);
    check("midreset_valid", int'(pixel_on_valid), 0);
    check("midreset_rom_addr", int'(rom_addr), 0);
    sb.delete();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) sh_base[i] = 9'h000;
    idle(1);
    send(88, 32, 1'b0);
    check("post_reset_slot0_blank", int'(rom_addr), 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
